rr_onehot_request_arbiter: RTL

- Upstream feeder for the 8-to-3 encoder.
- Captures rising-edge requests on N_REQ request lines and holds them as pending.
- Picks one pending request in round-robin order and presents it as a strictly one-hot grant vector, using a valid/ready handshake.
- The downstream encoder then converts the grant to a binary index. The grant is never zero and never has more than one bit set while grant_valid=1.

---
 rtl/rr_onehot_request_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/rr_onehot_request_arbiter.sv
// Round-robin arbiter feeding the 8-to-3 encoder: captures request rising edges as pending
// bits and issues one strictly one-hot grant at a time over a valid/ready handshake.
// Optional build macro RR_ARB_INPUT_SYNC_EN adds a 2-flop synchroniser on req_in.
module rr_onehot_request_arbiter #(
  parameter  int N_REQ = 8,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic [N_REQ-1:0] pending,
  output logic             drop_pulse
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [N_REQ-1:0] req_in_s;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] pick_idx;
  logic             handshake;

`ifdef RR_ARB_INPUT_SYNC_EN
  logic [N_REQ-1:0] sync_1;
  logic [N_REQ-1:0] sync_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= req_in;
      sync_2 <= sync_1;
    end
  end

  assign req_in_s = sync_2;
`else
  assign req_in_s = req_in;
`endif

  assign rise      = req_in_s & ~req_q;
  assign handshake = (state == GRANT) && grant_ready;
  assign clr       = handshake ? grant : '0;

  // First pending bit at or above ptr, wrapping; the PTR_W-bit add wraps modulo N_REQ.
  always_comb begin
    logic [PTR_W-1:0] cand;
    logic             found;
    cand     = '0;
    found    = 1'b0;
    pick_idx = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + PTR_W'(i);
      if (!found && pending[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // NOTE: every register here uses <= so all next-state terms see the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_q       <= '0;
      pending     <= '0;
      ptr         <= '0;
      gnt_idx     <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      req_q      <= req_in_s;
      // A rise on the bit being cleared this edge keeps it pending.
      pending    <= (pending & ~clr) | rise;
      drop_pulse <= |(rise & pending & ~clr);

      case (state)
        IDLE: begin
          if (|pending) begin
            grant       <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            gnt_idx     <= pick_idx;
            grant_valid <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            ptr         <= gnt_idx + 1'b1;
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
